// File: rtl/intr_arbiter.sv
// Round-robin interrupt arbiter for KCPSM6: merges NUM_SRC edge-triggered sources onto one
// interrupt line, runs the interrupt/ack/EOI handshake and exposes its registers as I/O ports.
module intr_arbiter #(
    parameter int          NUM_SRC     = 4,
    parameter int          EOI_TIMEOUT = 20000,
    parameter logic [7:0]  BASE_PORT   = 8'hE0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [7:0]         port_id,
    input  logic [7:0]         data_in,
    input  logic               write_strobe,
    input  logic               k_write_strobe,
    input  logic               read_strobe,
    output logic [7:0]         data_out,
    output logic               interrupt,
    input  logic               interrupt_ack,
    output logic [NUM_SRC-1:0] lost
);

    localparam int          TW   = $clog2(EOI_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(EOI_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2} state_t;

    state_t               state, next_state;
    logic [NUM_SRC-1:0]   src_q, pend, mask, cause;
    logic [NUM_SRC-1:0]   edges, req, gnt_oh, clr;
    logic [2:0]           rr, grant_idx, rr_next;
    logic                 grant_valid, do_grant, timeout_hit;
    logic [TW-1:0]        timer;
    logic                 timeout_sticky;
    logic                 wr, wr_mask, wr_eoi, rd_lost, rd_stat;
    logic [7:0]           offs, rd_data;
    logic                 unused_data;

    assign unused_data = ^data_in;

    assign offs    = port_id - BASE_PORT;
    assign wr      = write_strobe | k_write_strobe;
    assign wr_mask = wr && (offs == 8'd2);
    assign wr_eoi  = wr && (offs == 8'd5);
    assign rd_lost = read_strobe && (offs == 8'd3);
    assign rd_stat = read_strobe && (offs == 8'd4);

    assign edges = src_in & ~src_q;
    assign req   = pend & mask;

    // Walk the offsets downward so the lowest offset from rr (the round-robin winner) is kept.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 3'd0;
        gnt_oh      = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            int j;
            j = (int'(rr) + k) % NUM_SRC;
            if (req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(j);
                gnt_oh      = '0;
                gnt_oh[j]   = 1'b1;
            end
        end
    end

    assign rr_next = (grant_idx == 3'(NUM_SRC - 1)) ? 3'd0 : grant_idx + 3'd1;

    always_comb begin
        next_state  = state;
        do_grant    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    do_grant   = 1'b1;
                    next_state = ASSERT;
                end
            end
            ASSERT: begin
                if (interrupt_ack) next_state = SERVICE;
            end
            SERVICE: begin
                if (wr_eoi) begin
                    next_state = IDLE;
                end else if (timer == TMAX) begin
                    next_state  = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= next_state;
            interrupt <= (next_state == ASSERT);
        end
    end

    assign clr = do_grant ? gnt_oh : '0;

    always_comb begin
        rd_data = '0;
        case (offs)
            8'd0: rd_data[NUM_SRC-1:0] = cause;
            8'd1: rd_data[NUM_SRC-1:0] = pend;
            8'd2: rd_data[NUM_SRC-1:0] = mask;
            8'd3: rd_data[NUM_SRC-1:0] = lost;
            8'd4: rd_data = {timeout_sticky, 5'b0, state};
            default: rd_data = '0;
        endcase
    end

    // A new edge beats both the grant clear and the clear-on-read in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q          <= '0;
            pend           <= '0;
            lost           <= '0;
            mask           <= '0;
            cause          <= '0;
            rr             <= 3'd0;
            timer          <= '0;
            timeout_sticky <= 1'b0;
            data_out       <= 8'h00;
        end else begin
            src_q    <= src_in;
            pend     <= (pend & ~clr) | edges;
            lost     <= (lost & ~{NUM_SRC{rd_lost}}) | (edges & pend & ~clr);
            data_out <= rd_data;
            if (wr_mask) mask <= data_in[NUM_SRC-1:0];
            if (do_grant) begin
                cause <= gnt_oh;
                rr    <= rr_next;
            end else if (state == SERVICE && next_state == IDLE) begin
                cause <= '0;
            end
            if (state == SERVICE && next_state == SERVICE) timer <= timer + 1'b1;
            else                                           timer <= '0;
            if (timeout_hit)  timeout_sticky <= 1'b1;
            else if (rd_stat) timeout_sticky <= 1'b0;
        end
    end

endmodule
